// File: rtl/tlul_to_ibex_mem_dev_pkg.sv
// Shared types and helpers for the TL-UL device-side adapter onto an Ibex-style memory port.
package tlul_to_ibex_mem_dev_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'h0,
    A_PUT_PARTIAL = 3'h1,
    A_GET         = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'h0,
    D_ACCESS_ACK_DATA = 3'h1
  } tl_d_op_e;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [7:0]  source;
    logic [1:0]  size;
    logic        err;
    logic        done;
    logic [31:0] data;
  } rsp_entry_t;

  // True when the A-channel request must be answered locally with d_error.
  function automatic logic tl_req_err(input logic [2:0] op,
                                      input logic [1:0] size,
                                      input logic [3:0] mask,
                                      input logic [1:0] addr_lsb,
                                      input logic       chk_align);
    logic [3:0] full_mask;
    logic       bad_op;
    logic       misalign;
    bad_op = (op != A_GET) && (op != A_PUT_FULL) && (op != A_PUT_PARTIAL);
    case (size)
      2'd0: begin
        full_mask = 4'b0001 << addr_lsb;
        misalign  = 1'b0;
      end
      2'd1: begin
        full_mask = addr_lsb[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lsb[0];
      end
      default: begin
        full_mask = 4'b1111;
        misalign  = (addr_lsb != 2'b00);
      end
    endcase
    return bad_op || (size == 2'd3) || (mask == 4'h0) ||
           ((op == A_PUT_FULL) && (mask != full_mask)) ||
           (chk_align && misalign);
  endfunction

  // Response integrity: header parity on top of per-byte data parity.
  function automatic logic [4:0] tlul_rsp_intg_gen(input logic [2:0]  op,
                                                   input logic [1:0]  size,
                                                   input logic [7:0]  source,
                                                   input logic        err,
                                                   input logic [31:0] data);
    return {^{op, size, source, err}, ^data[31:24], ^data[23:16], ^data[15:8], ^data[7:0]};
  endfunction

endpackage

// File: rtl/tlul_to_ibex_mem_dev_if.sv
// TL-UL A/D channel bundle and Ibex-style req/gnt/rvalid memory port bundle.
interface tlul_bus_if;
  logic                                 a_valid;
  logic [2:0]                           a_opcode;
  logic [1:0]                           a_size;
  logic [7:0]                           a_source;
  logic [31:0]                          a_address;
  logic [3:0]                           a_mask;
  logic [31:0]                          a_data;
  logic                                 a_ready;
  logic                                 d_valid;
  tlul_to_ibex_mem_dev_pkg::tl_d_op_e   d_opcode;
  logic [2:0]                           d_param;
  logic [1:0]                           d_size;
  logic [7:0]                           d_source;
  logic                                 d_sink;
  logic [31:0]                          d_data;
  logic [4:0]                           d_user;
  logic                                 d_error;
  logic                                 d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );
endinterface

interface ibex_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/tlul_dev_rsp_tracker.sv
// In-order response tracker: FIFO of accepted requests, completed out of band by rvalid.
module tlul_dev_rsp_tracker
  import tlul_to_ibex_mem_dev_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  rsp_entry_t      push_entry,
  input  logic            cpl_valid,
  input  logic [31:0]     cpl_data,
  input  logic            cpl_err,
  input  logic            pop,
  output logic            head_valid,
  output rsp_entry_t      head,
  output logic [CntW-1:0] count
);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [PtrW:0]   DepthExt = (PtrW + 1)'(Depth);

  rsp_entry_t       entries_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q, cpl_idx;
  logic [PtrW:0]    scan;
  logic             cpl_hit;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Walk from the head so the oldest still-pending entry takes the completion.
  always_comb begin
    cpl_hit = 1'b0;
    cpl_idx = '0;
    scan    = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      scan = {1'b0, rd_ptr_q} + (PtrW + 1)'(i);
      if (scan >= DepthExt) scan = scan - DepthExt;
      if (!cpl_hit && valid_q[scan[PtrW-1:0]] && !entries_q[scan[PtrW-1:0]].done) begin
        cpl_hit = 1'b1;
        cpl_idx = scan[PtrW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) entries_q[i] <= '0;
    end else begin
      if (push) begin
        entries_q[wr_ptr_q] <= push_entry;
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (cpl_valid && cpl_hit) begin
        entries_q[cpl_idx].data <= cpl_data;
        entries_q[cpl_idx].err  <= cpl_err;
        entries_q[cpl_idx].done <= 1'b1;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign head       = entries_q[rd_ptr_q];
  assign head_valid = valid_q[rd_ptr_q];
  assign count      = count_q;

  rvalid_has_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cpl_valid |-> cpl_hit);

endmodule

// File: rtl/tlul_to_ibex_mem_dev.sv
// TL-UL device adapter: issues legal A-channel requests on an Ibex memory port, answers in order.
module tlul_to_ibex_mem_dev
  import tlul_to_ibex_mem_dev_pkg::*;
#(
  parameter int unsigned Outstanding   = 2,
  parameter bit          ErrOnMisalign = 1'b1
) (
  input logic        clk_i,
  input logic        rst_ni,
  tlul_bus_if.slave  tl,
  ibex_mem_if.master mem
);

  localparam int unsigned CntW = $clog2(Outstanding + 1);

  logic            ready_q;
  logic            hold_valid, hold_we;
  logic [29:0]     hold_addr;
  logic [3:0]      hold_be;
  logic [31:0]     hold_wdata;
  logic [2:0]      hold_opcode;
  logic [7:0]      hold_source;
  logic [1:0]      hold_size;
  logic            accept, req_err, grant, push, pop, head_valid;
  rsp_entry_t      push_entry, head;
  logic [CntW-1:0] trk_count;

  // hold_valid is known 0 past the first term, so count+hold reduces to count.
  assign tl.a_ready = ready_q && !hold_valid && (trk_count < CntW'(Outstanding));
  assign accept     = tl.a_valid && tl.a_ready;
  assign req_err    = tl_req_err(tl.a_opcode, tl.a_size, tl.a_mask, tl.a_address[1:0],
                                 ErrOnMisalign);
  assign grant      = hold_valid && mem.gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid  <= 1'b0;
      hold_we     <= 1'b0;
      hold_addr   <= '0;
      hold_be     <= '0;
      hold_wdata  <= '0;
      hold_opcode <= '0;
      hold_source <= '0;
      hold_size   <= '0;
    end else if (accept && !req_err) begin
      hold_valid  <= 1'b1;
      hold_we     <= (tl.a_opcode != A_GET);
      hold_addr   <= tl.a_address[31:2];
      hold_be     <= tl.a_mask;
      hold_wdata  <= tl.a_data;
      hold_opcode <= tl.a_opcode;
      hold_source <= tl.a_source;
      hold_size   <= tl.a_size;
    end else if (grant) begin
      hold_valid  <= 1'b0;
    end
  end

  // Error requests and granted requests never coincide: accept needs an empty hold.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (accept && req_err) begin
      push              = 1'b1;
      push_entry.opcode = tl.a_opcode;
      push_entry.source = tl.a_source;
      push_entry.size   = tl.a_size;
      push_entry.err    = 1'b1;
      push_entry.done   = 1'b1;
      push_entry.data   = ERR_DATA;
    end else if (grant) begin
      push              = 1'b1;
      push_entry.opcode = hold_opcode;
      push_entry.source = hold_source;
      push_entry.size   = hold_size;
    end
  end

  tlul_dev_rsp_tracker #(
    .Depth(Outstanding)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (push),
    .push_entry (push_entry),
    .cpl_valid  (mem.rvalid),
    .cpl_data   (mem.rdata),
    .cpl_err    (mem.err),
    .pop        (pop),
    .head_valid (head_valid),
    .head       (head),
    .count      (trk_count)
  );

  assign mem.req   = hold_valid;
  assign mem.we    = hold_we;
  assign mem.addr  = {hold_addr, 2'b00};
  assign mem.be    = hold_be;
  assign mem.wdata = hold_wdata;

  assign tl.d_valid  = head_valid && head.done;
  assign tl.d_opcode = (head.opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
  assign tl.d_param  = '0;
  assign tl.d_size   = head.size;
  assign tl.d_source = head.source;
  assign tl.d_sink   = 1'b0;
  assign tl.d_error  = head.err;
  assign tl.d_data   = head.err ? ERR_DATA : ((head.opcode == A_GET) ? head.data : '0);
  assign tl.d_user   = tlul_rsp_intg_gen(tl.d_opcode, tl.d_size, tl.d_source, tl.d_error,
                                         tl.d_data);
  assign pop         = tl.d_valid && tl.d_ready;

endmodule

// File: tb/tb_tlul_to_ibex_mem_dev.sv
// Directed bench for the TL-UL device adapter with hand-computed expectations.
module tb_tlul_to_ibex_mem_dev;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tlul_bus_if tl_bus ();
  ibex_mem_if mem_bus ();

  tlul_to_ibex_mem_dev #(
    .Outstanding   (2),
    .ErrOnMisalign (1'b1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl     (tl_bus),
    .mem    (mem_bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    bit          err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    tl_bus.a_opcode  = op;
    tl_bus.a_size    = size;
    tl_bus.a_source  = src;
    tl_bus.a_address = addr;
    tl_bus.a_mask    = mask;
    tl_bus.a_data    = data;
    tl_bus.a_valid   = 1'b1;
    check("a_ready_before_send", tl_bus.a_ready, 1);
    step();
    tl_bus.a_valid   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tl_bus.a_valid = 0; tl_bus.a_opcode = 0; tl_bus.a_size = 0; tl_bus.a_source = 0;
    tl_bus.a_address = 0; tl_bus.a_mask = 0; tl_bus.a_data = 0; tl_bus.d_ready = 1;
    mem_bus.gnt = 0; mem_bus.rvalid = 0; mem_bus.rdata = 0; mem_bus.err = 0;

    vecs[0] = '{3'd2, 2'd2, 32'h0000_0000, 4'hF, 1'b1};
    vecs[1] = '{3'd4, 2'd2, 32'h0000_0102, 4'hF, 1'b1};
    vecs[2] = '{3'd1, 2'd2, 32'h0000_0008, 4'h0, 1'b1};
    vecs[3] = '{3'd0, 2'd2, 32'h0000_0010, 4'h3, 1'b1};
    vecs[4] = '{3'd0, 2'd0, 32'h0000_0101, 4'h2, 1'b0};
    vecs[5] = '{3'd0, 2'd1, 32'h0000_0102, 4'hC, 1'b0};
    vecs[6] = '{3'd0, 2'd1, 32'h0000_0102, 4'h3, 1'b1};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req", mem_bus.req, 0);
    check("rst_we", mem_bus.we, 0);
    check("rst_addr", mem_bus.addr, 0);
    check("rst_be", mem_bus.be, 0);
    check("rst_wdata", mem_bus.wdata, 0);
    check("rst_d_valid", tl_bus.d_valid, 0);
    check("rst_a_ready", tl_bus.a_ready, 0);
    rst_ni = 1'b1;
    step();
    check("post_rst_a_ready", tl_bus.a_ready, 1);

    // 1: Get with same-cycle grant
    send(3'd4, 2'd2, 8'd3, 32'h0000_0100, 4'hF, 32'h0);
    check("t1_req", mem_bus.req, 1);
    check("t1_addr", mem_bus.addr, 32'h100);
    check("t1_be", mem_bus.be, 4'hF);
    check("t1_we", mem_bus.we, 0);
    mem_bus.gnt = 1;
    step();
    mem_bus.gnt = 0;
    check("t1_req_drop", mem_bus.req, 0);
    mem_bus.rvalid = 1; mem_bus.rdata = 32'hDEAD_BEEF;
    step();
    mem_bus.rvalid = 0;
    check("t1_d_valid", tl_bus.d_valid, 1);
    check("t1_d_opcode", tl_bus.d_opcode, 1);
    check("t1_d_source", tl_bus.d_source, 3);
    check("t1_d_size", tl_bus.d_size, 2);
    check("t1_d_data", tl_bus.d_data, 32'hDEAD_BEEF);
    check("t1_d_error", tl_bus.d_error, 0);
    check("t1_d_user", tl_bus.d_user, 5'h05);
    step();
    check("t1_popped", tl_bus.d_valid, 0);

    // 2: PutPartialData upper half-word
    send(3'd1, 2'd1, 8'd5, 32'h0000_0006, 4'hC, 32'hAB12_0000);
    check("t2_req", mem_bus.req, 1);
    check("t2_we", mem_bus.we, 1);
    check("t2_addr", mem_bus.addr, 32'h4);
    check("t2_be", mem_bus.be, 4'hC);
    check("t2_wdata", mem_bus.wdata, 32'hAB12_0000);
    mem_bus.gnt = 1;
    step();
    mem_bus.gnt = 0;
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h1234_5678;
    step();
    mem_bus.rvalid = 0;
    check("t2_d_valid", tl_bus.d_valid, 1);
    check("t2_d_opcode", tl_bus.d_opcode, 0);
    check("t2_d_data", tl_bus.d_data, 0);
    check("t2_d_error", tl_bus.d_error, 0);
    check("t2_d_source", tl_bus.d_source, 5);
    step();
    check("t2_popped", tl_bus.d_valid, 0);

    // 3: error request queued behind a slow read
    send(3'd4, 2'd2, 8'd1, 32'h0000_0200, 4'hF, 32'h0);
    mem_bus.gnt = 1;
    step();
    mem_bus.gnt = 0;
    send(3'd4, 2'd3, 8'd2, 32'h0000_0300, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check("t3_err_no_req", mem_bus.req, 0);
      check("t3_err_waits", tl_bus.d_valid, 0);
      step();
    end
    mem_bus.rvalid = 1; mem_bus.rdata = 32'hCAFE_F00D;
    step();
    mem_bus.rvalid = 0;
    check("t3_rd_valid", tl_bus.d_valid, 1);
    check("t3_rd_source", tl_bus.d_source, 1);
    check("t3_rd_data", tl_bus.d_data, 32'hCAFE_F00D);
    check("t3_rd_error", tl_bus.d_error, 0);
    step();
    check("t3_err_valid", tl_bus.d_valid, 1);
    check("t3_err_source", tl_bus.d_source, 2);
    check("t3_err_error", tl_bus.d_error, 1);
    check("t3_err_data", tl_bus.d_data, 32'hFFFF_FFFF);
    check("t3_err_size", tl_bus.d_size, 3);
    check("t3_err_opcode", tl_bus.d_opcode, 1);
    step();
    check("t3_empty", tl_bus.d_valid, 0);

    // Legality table
    foreach (vecs[v]) begin
      send(vecs[v].op, vecs[v].size, 8'(8'h40 + v), vecs[v].addr, vecs[v].mask, 32'h5555_AAAA);
      if (vecs[v].err) begin
        check("tbl_err_no_req", mem_bus.req, 0);
        check("tbl_err_valid", tl_bus.d_valid, 1);
        check("tbl_err_error", tl_bus.d_error, 1);
        check("tbl_err_data", tl_bus.d_data, 32'hFFFF_FFFF);
        check("tbl_err_source", tl_bus.d_source, 32'h40 + v);
      end else begin
        check("tbl_ok_req", mem_bus.req, 1);
        mem_bus.gnt = 1;
        step();
        mem_bus.gnt = 0;
        mem_bus.rvalid = 1; mem_bus.rdata = 32'h0F0F_0F0F;
        step();
        mem_bus.rvalid = 0;
        check("tbl_ok_valid", tl_bus.d_valid, 1);
        check("tbl_ok_error", tl_bus.d_error, 0);
        check("tbl_ok_data", tl_bus.d_data, 0);
      end
      step();
      check("tbl_empty", tl_bus.d_valid, 0);
    end

    // 4/5: fill to Outstanding, then backpressure D while a second rvalid lands
    mem_bus.gnt = 1;
    send(3'd4, 2'd2, 8'd4, 32'h0000_0010, 4'hF, 32'h0);
    check("t4_a_ready_hold", tl_bus.a_ready, 0);
    step();
    send(3'd4, 2'd2, 8'd5, 32'h0000_0014, 4'hF, 32'h0);
    step();
    mem_bus.gnt = 0;
    check("t4_a_ready_full", tl_bus.a_ready, 0);
    check("t4_req_idle", mem_bus.req, 0);
    tl_bus.d_ready = 0;
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h1111_1111;
    step();
    mem_bus.rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      check("t5_hold_valid", tl_bus.d_valid, 1);
      check("t5_hold_data", tl_bus.d_data, 32'h1111_1111);
      check("t5_hold_source", tl_bus.d_source, 4);
      check("t5_hold_opcode", tl_bus.d_opcode, 1);
      check("t4_still_full", tl_bus.a_ready, 0);
      if (k == 0) begin
        mem_bus.rvalid = 1; mem_bus.rdata = 32'h2222_2222;
      end
      step();
      mem_bus.rvalid = 0;
    end
    tl_bus.d_ready = 1;
    step();
    check("t4_a_ready_after_pop", tl_bus.a_ready, 1);
    check("t5_second_valid", tl_bus.d_valid, 1);
    check("t5_second_data", tl_bus.d_data, 32'h2222_2222);
    check("t5_second_source", tl_bus.d_source, 5);
    step();
    check("t5_empty", tl_bus.d_valid, 0);

    // 6: reset while a request is held and another is pending
    send(3'd4, 2'd2, 8'd6, 32'h0000_0040, 4'hF, 32'h0);
    mem_bus.gnt = 1;
    step();
    mem_bus.gnt = 0;
    send(3'd4, 2'd2, 8'd7, 32'h0000_0044, 4'hF, 32'h0);
    check("t6_req_before_rst", mem_bus.req, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_req", mem_bus.req, 0);
    check("t6_rst_d_valid", tl_bus.d_valid, 0);
    check("t6_rst_a_ready", tl_bus.a_ready, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();
    check("t6_rel_a_ready", tl_bus.a_ready, 1);
    for (int k = 0; k < 2; k++) begin
      check("t6_no_stale_rsp", tl_bus.d_valid, 0);
      step();
    end
    send(3'd4, 2'd2, 8'd8, 32'h0000_0080, 4'hF, 32'h0);
    check("t6_new_req", mem_bus.req, 1);
    check("t6_new_addr", mem_bus.addr, 32'h80);
    mem_bus.gnt = 1;
    step();
    mem_bus.gnt = 0;
    mem_bus.rvalid = 1; mem_bus.rdata = 32'h0BAD_CAFE;
    step();
    mem_bus.rvalid = 0;
    check("t6_new_valid", tl_bus.d_valid, 1);
    check("t6_new_data", tl_bus.d_data, 32'h0BAD_CAFE);
    check("t6_new_source", tl_bus.d_source, 8);
    step();
    check("t6_empty", tl_bus.d_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
